// File: rtl/data_memory_banked.sv
// ============================================================================
// Module      : data_memory_banked
// Description : Byte-addressed big-endian data memory with byte enables,
//               request/response handshake and a post-reset clear sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_banked #(
  parameter int DATA_BYTES = 3,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 24
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ReqValid,
  output logic                    Ready,
  input  logic                    MemWrite,
  input  logic [DATA_BYTES-1:0]   ByteEn,
  input  logic [ADDR_W-1:0]       Adresa,
  input  logic [8*DATA_BYTES-1:0] WriteData,
  output logic                    RespValid,
  output logic [8*DATA_BYTES-1:0] ReadData,
  output logic                    AddrErr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_nextState;
  logic [IDX_W-1:0]        r_clearCnt;
  logic                    w_clearDone;
  logic                    w_accept;
  logic                    w_outOfRange;
  logic [ADDR_W:0]         w_endAddr;
  logic [8*DATA_BYTES-1:0] w_rdWord;
  logic [IDX_W-1:0]        w_laneIdx [DATA_BYTES];
  logic [7:0]              r_mem     [DEPTH];
  logic                    r_respValid;
  logic                    r_addrErr;
  logic [8*DATA_BYTES-1:0] r_readData;

  // One extra bit so a start address near the top of the space cannot wrap into range.
  assign w_endAddr    = {1'b0, Adresa} + (ADDR_W+1)'(DATA_BYTES-1);
  assign w_outOfRange = (w_endAddr >= (ADDR_W+1)'(DEPTH));
  assign w_clearDone  = (r_clearCnt == IDX_W'(DEPTH-1));
  assign w_accept     = ReqValid && Ready;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_CLEAR: if (w_clearDone) w_nextState = S_IDLE;
      S_IDLE:  w_nextState = S_IDLE;
      default: w_nextState = S_CLEAR;
    endcase
  end

  always_comb begin
    Ready = 1'b0;
    case (r_state)
      S_IDLE:  Ready = 1'b1;
      default: Ready = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_clearCnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clearCnt <= w_clearDone ? '0 : r_clearCnt + 1'b1;
    end
  end

  // Lane k is byte Adresa+k and sits in the k-th most significant data byte.
  for (genvar k = 0; k < DATA_BYTES; k++) begin : g_lane
    assign w_laneIdx[k] = Adresa[IDX_W-1:0] + IDX_W'(k);
    assign w_rdWord[8*(DATA_BYTES-k)-1 -: 8] = r_mem[w_laneIdx[k]];
  end

  always_ff @(posedge Clock) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clearCnt] <= 8'h00;
    end else if (w_accept && MemWrite && !w_outOfRange) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (ByteEn[DATA_BYTES-1-k]) begin
          r_mem[w_laneIdx[k]] <= WriteData[8*(DATA_BYTES-k)-1 -: 8];
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_respValid <= 1'b0;
      r_addrErr   <= 1'b0;
      r_readData  <= '0;
    end else begin
      r_respValid <= w_accept;
      r_addrErr   <= w_accept && w_outOfRange;
      if (w_accept && !MemWrite) begin
        r_readData <= w_outOfRange ? '0 : w_rdWord;
      end
    end
  end

  assign RespValid = r_respValid;
  assign AddrErr   = r_addrErr;
  assign ReadData  = r_readData;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_banked.sv
// ============================================================================
// Module      : tb_data_memory_banked
// Description : Directed self-checking bench for data_memory_banked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_banked;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        Ready;
  logic        MemWrite = 1'b0;
  logic [2:0]  ByteEn = 3'b000;
  logic [23:0] Adresa = '0;
  logic [23:0] WriteData = '0;
  logic        RespValid;
  logic [23:0] ReadData;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  data_memory_banked #(.DATA_BYTES(3), .DEPTH(128), .ADDR_W(24)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .Ready     (Ready),
    .MemWrite  (MemWrite),
    .ByteEn    (ByteEn),
    .Adresa    (Adresa),
    .WriteData (WriteData),
    .RespValid (RespValid),
    .ReadData  (ReadData),
    .AddrErr   (AddrErr)
  );

  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at the falling edge; return just after the accepting edge.
  task automatic issue(input logic wr, input logic [2:0] be, input logic [23:0] addr,
                       input logic [23:0] wdata);
    @(negedge Clock);
    ReqValid  = 1'b1;
    MemWrite  = wr;
    ByteEn    = be;
    Adresa    = addr;
    WriteData = wdata;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
  endtask

  task automatic doWrite(input string tag, input logic [23:0] addr, input logic [2:0] be,
                         input logic [23:0] wdata, input logic expErr);
    issue(1'b1, be, addr, wdata);
    checkVal({tag, "_rv"}, 32'(RespValid), 32'd1);
    checkVal({tag, "_err"}, 32'(AddrErr), 32'(expErr));
  endtask

  task automatic doRead(input string tag, input logic [23:0] addr,
                        input logic [23:0] expData, input logic expErr);
    issue(1'b0, 3'b111, addr, 24'h0);
    checkVal({tag, "_rv"}, 32'(RespValid), 32'd1);
    checkVal({tag, "_data"}, 32'(ReadData), 32'(expData));
    checkVal({tag, "_err"}, 32'(AddrErr), 32'(expErr));
  endtask

  task automatic waitClear(input string tag);
    int cnt;
    cnt = 0;
    @(negedge Clock);
    Reset = 1'b0;
    while (!Ready && cnt < 300) begin
      @(posedge Clock);
      #1;
      cnt++;
    end
    checkVal({tag, "_cycles"}, 32'(cnt), 32'd128);
    checkVal({tag, "_ready"}, 32'(Ready), 32'd1);
  endtask

  initial begin
    // Reset state and clear sequence
    repeat (2) @(posedge Clock);
    #1;
    checkVal("rst_ready", 32'(Ready), 32'd0);
    checkVal("rst_rv", 32'(RespValid), 32'd0);
    checkVal("rst_err", 32'(AddrErr), 32'd0);
    checkVal("rst_data", 32'(ReadData), 32'd0);
    waitClear("clear1");
    doRead("rd10", 24'h000010, 24'h000000, 1'b0);
    @(posedge Clock);
    #1;
    checkVal("idle_rv", 32'(RespValid), 32'd0);

    // Full write, read-after-write, unaligned read
    doWrite("wr4", 24'h000004, 3'b111, 24'hA1B2C3, 1'b0);
    doRead("rd4", 24'h000004, 24'hA1B2C3, 1'b0);
    doRead("rd5", 24'h000005, 24'hB2C300, 1'b0);

    // Middle-lane-only write
    doWrite("wr4m", 24'h000004, 3'b010, 24'hFFFFFF, 1'b0);
    doRead("rd4m", 24'h000004, 24'hA1FFC3, 1'b0);

    // Range edges
    doWrite("wr7d", 24'h00007D, 3'b111, 24'h445566, 1'b0);
    doRead("rd7d", 24'h00007D, 24'h445566, 1'b0);
    doWrite("wr7e", 24'h00007E, 3'b111, 24'h112233, 1'b1);
    checkVal("wr7e_hold", 32'(ReadData), 32'h445566);
    doRead("rd7d_b", 24'h00007D, 24'h445566, 1'b0);
    doRead("rd7e", 24'h00007E, 24'h000000, 1'b1);
    doRead("rdfff", 24'hFFFFFF, 24'h000000, 1'b1);

    // Back-to-back writes then reads
    doWrite("bw0", 24'h000000, 3'b111, 24'h0A0B0C, 1'b0);
    doWrite("bw3", 24'h000003, 3'b111, 24'h0D0E0F, 1'b0);
    doWrite("bw6", 24'h000006, 3'b111, 24'h101112, 1'b0);
    doWrite("bw9", 24'h000009, 3'b111, 24'h131415, 1'b0);
    doRead("br0", 24'h000000, 24'h0A0B0C, 1'b0);
    doRead("br3", 24'h000003, 24'h0D0E0F, 1'b0);
    doRead("br6", 24'h000006, 24'h101112, 1'b0);
    doRead("br9", 24'h000009, 24'h131415, 1'b0);
    @(posedge Clock);
    #1;
    checkVal("b2b_idle_rv", 32'(RespValid), 32'd0);
    checkVal("b2b_idle_err", 32'(AddrErr), 32'd0);
    checkVal("b2b_idle_hold", 32'(ReadData), 32'h131415);

    // Reset while a read response is showing
    doWrite("wr4r", 24'h000004, 3'b111, 24'hA1B2C3, 1'b0);
    doRead("rd4r", 24'h000004, 24'hA1B2C3, 1'b0);
    issue(1'b0, 3'b111, 24'h000004, 24'h0);
    checkVal("pre_rst_rv", 32'(RespValid), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    checkVal("mid_rst_rv", 32'(RespValid), 32'd0);
    checkVal("mid_rst_ready", 32'(Ready), 32'd0);
    checkVal("mid_rst_data", 32'(ReadData), 32'd0);
    @(posedge Clock);
    waitClear("clear2");
    doRead("rd4z", 24'h000004, 24'h000000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
